// File: rtl/axis_ascon_aead128_framer.sv
// axis_ascon_aead128_framer
// Transmit-side front end for an axis_ascon_aead128 core. Takes one request per message
// (512-bit command plus AD/payload byte lengths) and sequences the core's slave streams in
// the fixed order cmd -> AD -> payload -> tag (decrypt only). Unframed 128-bit AD and
// payload beats from the sources get tlast/tkeep attached from the byte counts.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   s_req_*                   request: command word (bit 256 = encrypt), AD/payload lengths
//   s_ad_*, s_*, s_tag_*      unframed AD, payload and received-tag sources
//   m_cmd_*                   command to core (registered valid)
//   m_ad_*, m_*               framed AD and payload to core (combinational pass-through)
//   m_tag_*                   tag to core (decrypt only)
//   busy                      high whenever a message is in flight
module axis_ascon_aead128_framer #(
  parameter int unsigned len_w        = 16,
  parameter bit          keep_support = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_req_tvalid,
  output logic             s_req_tready,
  input  logic [511:0]     s_req_tdata,
  input  logic [len_w-1:0] s_req_ad_len,
  input  logic [len_w-1:0] s_req_p_len,
  input  logic             s_ad_tvalid,
  output logic             s_ad_tready,
  input  logic [127:0]     s_ad_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic [127:0]     s_tdata,
  input  logic             s_tag_tvalid,
  output logic             s_tag_tready,
  input  logic [127:0]     s_tag_tdata,
  output logic             m_cmd_tvalid,
  input  logic             m_cmd_tready,
  output logic [511:0]     m_cmd_tdata,
  output logic             m_ad_tvalid,
  input  logic             m_ad_tready,
  output logic             m_ad_tlast,
  output logic [127:0]     m_ad_tdata,
  output logic [15:0]      m_ad_tkeep,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [127:0]     m_tdata,
  output logic [15:0]      m_tkeep,
  output logic             m_tag_tvalid,
  input  logic             m_tag_tready,
  output logic [127:0]     m_tag_tdata,
  output logic             busy
);

  typedef enum logic [2:0] {StIdle, StCmd, StAd, StP, StTag} state_e;

  localparam logic [len_w-1:0] BeatBytes = len_w'(16);

  state_e           state_q, state_d;
  logic [511:0]     cmd_q;
  logic [len_w-1:0] ad_len_q, p_len_q;
  logic             enc_q;
  logic [len_w-1:0] rem_q, rem_d;

  logic             req_fire;
  logic             beat_last;
  logic [15:0]      beat_keep;
  logic [len_w-1:0] rem_dec;

  assign req_fire  = s_req_tvalid && s_req_tready;
  assign beat_last = (rem_q <= BeatBytes);
  // Counter saturates at 0 so the maximum length never wraps.
  assign rem_dec   = (rem_q > BeatBytes) ? (rem_q - BeatBytes) : '0;

  // rem_q keeps the original length's low nibble, so on the last beat it holds 1..16 bytes.
  always_comb begin
    beat_keep = 16'hFFFF;
    if (keep_support && beat_last && (rem_q[3:0] != 4'd0)) begin
      beat_keep = (16'h1 << rem_q[3:0]) - 16'h1;
    end
  end

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    s_req_tready = 1'b0;
    m_cmd_tvalid = 1'b0;
    m_cmd_tdata  = cmd_q;
    m_ad_tvalid  = 1'b0;
    s_ad_tready  = 1'b0;
    m_ad_tlast   = 1'b0;
    m_ad_tkeep   = 16'h0000;
    m_ad_tdata   = s_ad_tdata;
    m_tvalid     = 1'b0;
    s_tready     = 1'b0;
    m_tlast      = 1'b0;
    m_tkeep      = 16'h0000;
    m_tdata      = s_tdata;
    m_tag_tvalid = 1'b0;
    s_tag_tready = 1'b0;
    m_tag_tdata  = s_tag_tdata;

    case (state_q)
      StIdle: begin
        s_req_tready = ~rst;
        if (s_req_tvalid && !rst) state_d = StCmd;
      end
      StCmd: begin
        m_cmd_tvalid = 1'b1;
        if (m_cmd_tready) begin
          if (ad_len_q != '0) begin
            state_d = StAd;
            rem_d   = ad_len_q;
          end else if (p_len_q != '0) begin
            state_d = StP;
            rem_d   = p_len_q;
          end else if (!enc_q) begin
            state_d = StTag;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StAd: begin
        m_ad_tvalid = s_ad_tvalid;
        s_ad_tready = m_ad_tready;
        m_ad_tlast  = beat_last;
        m_ad_tkeep  = beat_keep;
        if (s_ad_tvalid && m_ad_tready) begin
          rem_d = rem_dec;
          if (beat_last) begin
            if (p_len_q != '0) begin
              state_d = StP;
              rem_d   = p_len_q;
            end else if (!enc_q) begin
              state_d = StTag;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      StP: begin
        m_tvalid = s_tvalid;
        s_tready = m_tready;
        m_tlast  = beat_last;
        m_tkeep  = beat_keep;
        if (s_tvalid && m_tready) begin
          rem_d = rem_dec;
          if (beat_last) state_d = enc_q ? StIdle : StTag;
        end
      end
      StTag: begin
        m_tag_tvalid = s_tag_tvalid;
        s_tag_tready = m_tag_tready;
        if (s_tag_tvalid && m_tag_tready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      rem_q    <= '0;
      cmd_q    <= '0;
      ad_len_q <= '0;
      p_len_q  <= '0;
      enc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (req_fire) begin
        cmd_q    <= s_req_tdata;
        ad_len_q <= s_req_ad_len;
        p_len_q  <= s_req_p_len;
        enc_q    <= s_req_tdata[256];
      end
    end
  end

endmodule

// File: doc/axis_ascon_aead128_framer.md
Name: axis_ascon_aead128_framer

Overview:
- Transmit-side front end for an axis_ascon_aead128 core.
- Accepts one request per message: a 512-bit command word plus associated-data (AD) and payload byte lengths.
- Sequences the core's slave interfaces in a fixed order: cmd, then AD, then payload, then tag (decryption only).
- Attaches tlast/tkeep to unframed 128-bit AD and payload streams, so sources need not know AXI-Stream framing.

Parameters:
- len_w, 16, width of the byte-length fields.
- keep_support, 1, 1 = partial last beats allowed; 0 = lengths must be multiples of 16, tkeep always 16'hFFFF.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- s_req_tvalid  in  1  request valid.
- s_req_tready  out  1  request ready.
- s_req_tdata  in  512  command word, forwarded verbatim; bit 256 = 1 encrypt, 0 decrypt.
- s_req_ad_len  in  len_w  AD length in bytes.
- s_req_p_len  in  len_w  payload length in bytes.
- s_ad_tvalid / s_ad_tready / s_ad_tdata  in/out/in  1/1/128  unframed AD beats.
- s_tvalid / s_tready / s_tdata  in/out/in  1/1/128  unframed payload beats.
- s_tag_tvalid / s_tag_tready / s_tag_tdata  in/out/in  1/1/128  received tag (decrypt only).
- m_cmd_tvalid / m_cmd_tready / m_cmd_tdata  out/in/out  1/1/512  to core s_cmd.
- m_ad_tvalid / m_ad_tready / m_ad_tlast / m_ad_tdata / m_ad_tkeep  out/in/out/out/out  1/1/1/128/16  to core s_ad.
- m_tvalid / m_tready / m_tlast / m_tdata / m_tkeep  out/in/out/out/out  1/1/1/128/16  to core s_.
- m_tag_tvalid / m_tag_tready / m_tag_tdata  out/in/out  1/1/128  to core s_tag.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any time, including mid-message):
  - State goes to IDLE; counters and latched request are cleared.
  - All m_*_tvalid = 0, s_req_tready = 0 while rst is high, busy = 0.
  - A partially sent message is abandoned; no further beats from it are emitted.
- FSM states: IDLE, CMD, AD, P, TAG.
- IDLE:
  - s_req_tready = 1.
  - On request handshake, latch cmd, ad_len, p_len and encrypt bit; go to CMD next cycle.
- CMD:
  - m_cmd_tvalid = 1 (registered); m_cmd_tdata = latched cmd.
  - On handshake, go to AD if ad_len != 0, else P if p_len != 0, else TAG if decrypt, else IDLE.
- AD:
  - Combinational pass-through, zero latency: m_ad_tvalid = s_ad_tvalid, s_ad_tready = m_ad_tready, tdata passes unchanged.
  - Remaining-byte counter starts at ad_len and decrements by 16 per handshake.
  - tlast = (remaining <= 16).
  - tkeep = 16'hFFFF on non-last beats; on the last beat, low (ad_len mod 16) bits set, or all 16 bits if mod is 0. Byte i is tdata[8i+7:8i] and maps to tkeep[i].
  - After the last-beat handshake, go to P / TAG / IDLE by the same rule as CMD.
- P: identical to AD using p_len and the payload stream. After last beat, go to TAG if decrypt, else IDLE.
- TAG:
  - Pass-through s_tag to m_tag.
  - After handshake, go to IDLE.
- Valid gating:
  - Every m_*_tvalid and s_*_tready is 0 outside its own state, whatever the inputs.
  - Framer-side ready never depends on framer-side valid; no combinational valid→ready loop.
- Zero length: the stream is skipped entirely; a tkeep = 0 beat is never emitted.
- Back-to-back requests: a new request is accepted in the first IDLE cycle after completion, so there is one idle cycle between messages.
- Source stalls: s_ad_tvalid / s_tvalid low mid-message holds the state; no timeout.
- keep_support = 0 with a length not a multiple of 16: behaviour is undefined. Formal harnesses must assume this never occurs.
- Lengths are unsigned; the maximum 2^len_w − 1 must work with no counter wrap. The counter is len_w bits wide and saturates at 0.

Test Plan:
- Encrypt, ad_len = 20, p_len = 32 → 1 cmd beat; AD beats keep FFFF then 000F with tlast on the 2nd; payload 2 beats all FFFF, tlast on the 2nd; no tag; busy falls after the last payload handshake.
- Decrypt, ad_len = 0, p_len = 1 → cmd, no AD beats, 1 payload beat keep 0001 tlast = 1, then tag forwarded unchanged.
- Encrypt, ad_len = 0, p_len = 0 → cmd beat only, back to IDLE; decrypt with the same lengths → cmd then tag.
- Random m_*_tready and s_*_tvalid stalls on a 5-message run with lengths 1..100 → byte/beat counts and tkeep match the model; no valid outside the active state.
- Assert rst during payload beat 3 of 6 → all valids drop the same cycle; next request after release produces a complete, correct message.
- Chained with a reset-free encrypt core, decrypt core and formal FIFOs in a loopback harness → decrypted AD/payload equal the source, decrypt tag output == 0.
